// File: rtl/serial_to_parallel_collector_pkg.sv
// ----------------------------------------------------------------------------
// serial_to_parallel_collector_pkg
// Shared constants for the shift-register chain and its serial-to-parallel
// collector.
//   MSB_FIRST_C / LSB_FIRST_C : bit-order selector values
//   SR_WIDTH                  : default word width of the shift-register chain
// ----------------------------------------------------------------------------
package serial_to_parallel_collector_pkg;

   localparam int MSB_FIRST_C = 1;
   localparam int LSB_FIRST_C = 0;
   localparam int SR_WIDTH    = 4;

endpackage : serial_to_parallel_collector_pkg

// File: rtl/serial_to_parallel_collector_out_reg.sv
// ----------------------------------------------------------------------------
// collector_out_reg
// One-word valid/ready holding register with sticky overflow detection.
// A word offered on 'load' is accepted when the register is empty or is being
// drained on the same edge; otherwise the word is dropped and ovf is set.
// Ports:
//   clk        : rising-edge clock
//   clr        : asynchronous active-low reset
//   load       : a completed word is offered this edge
//   word       : the completed word
//   dout_ready : consumer accepts the held word when dout_valid=1
//   ovf_clr    : synchronous clear of ovf (an overflow on the same edge wins)
//   dout       : held word
//   dout_valid : held word is valid
//   ovf        : sticky flag, a completed word was dropped
// ----------------------------------------------------------------------------
module collector_out_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             dout_ready,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             ovf
);

   logic xfer;
   logic accept;
   logic drop;

   assign xfer   = dout_valid & dout_ready;
   // Register is free if empty or emptied by a transfer on this edge.
   assign accept = load & (~dout_valid | dout_ready);
   assign drop   = load & dout_valid & ~dout_ready;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (accept) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else if (xfer) begin
            dout_valid <= 1'b0;
         end

         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule : collector_out_reg

// File: rtl/serial_to_parallel_collector.sv
// ----------------------------------------------------------------------------
// serial_to_parallel_collector
// Collects WIDTH qualified serial bits from the shift-register chain into a
// parallel word and presents it on a valid/ready port with a one-word holding
// register and a sticky overflow flag. The bit counter always wraps on the
// WIDTH-th bit, so word alignment survives dropped words.
// Ports:
//   clk        : rising-edge clock
//   clr        : asynchronous active-low reset
//   din        : serial data bit
//   din_en     : din is sampled only when 1
//   sclr       : synchronous clear of the partial word (priority over din_en)
//   dout       : assembled word
//   dout_valid : word available
//   dout_ready : consumer accepts word
//   ovf        : sticky overflow flag
//   ovf_clr    : synchronous clear of ovf
//   bit_cnt    : bits collected into the current partial word
// ----------------------------------------------------------------------------
module serial_to_parallel_collector
   import serial_to_parallel_collector_pkg::*;
#(
   parameter int WIDTH     = SR_WIDTH,
   parameter int CNT_W     = $clog2(WIDTH),
   parameter int MSB_FIRST = MSB_FIRST_C
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             din,
   input  logic             din_en,
   input  logic             sclr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sr_p0;
   logic [WIDTH-1:0] sr_nxt;
   logic [CNT_W-1:0] cnt_p0;
   logic             done;

   // Bit order is a static choice: either shift left with din entering the
   // LSB (first bit ends in MSB) or shift right with din entering the MSB.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                 input logic             b);
      if (MSB_FIRST == MSB_FIRST_C) begin
         return {sr[WIDTH-2:0], b};
      end else begin
         return {b, sr[WIDTH-1:1]};
      end
   endfunction

   assign sr_nxt = shift_in(sr_p0, din);
   // sclr suppresses completion so no word is offered on a clear edge.
   assign done   = din_en & ~sclr & (cnt_p0 == CNT_LAST);

   // ---- stage 0: serial collection ----
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sr_p0  <= '0;
         cnt_p0 <= '0;
      end else if (sclr) begin
         sr_p0  <= '0;
         cnt_p0 <= '0;
      end else if (din_en) begin
         sr_p0  <= sr_nxt;
         cnt_p0 <= done ? '0 : cnt_p0 + CNT_W'(1);
      end
   end

   // ---- stage 1: output holding register ----
   collector_out_reg #(
      .WIDTH (WIDTH)
   ) u_out (
      .clk        (clk),
      .clr        (clr),
      .load       (done),
      .word       (sr_nxt),
      .dout_ready (dout_ready),
      .ovf_clr    (ovf_clr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .ovf        (ovf)
   );

   assign bit_cnt = cnt_p0;

endmodule : serial_to_parallel_collector

// File: tb/tb_serial_to_parallel_collector.sv
module tb_serial_to_parallel_collector;

   logic       clk = 1'b0;
   logic       clr;
   logic       din, din_en, sclr, dout_ready, ovf_clr;
   logic [3:0] dout_m, dout_l;
   logic       vld_m, vld_l, ovf_m, ovf_l;
   logic [1:0] cnt_m, cnt_l;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   serial_to_parallel_collector #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
      .clk(clk), .clr(clr), .din(din), .din_en(din_en), .sclr(sclr),
      .dout(dout_m), .dout_valid(vld_m), .dout_ready(dout_ready),
      .ovf(ovf_m), .ovf_clr(ovf_clr), .bit_cnt(cnt_m));

   serial_to_parallel_collector #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .clr(clr), .din(din), .din_en(din_en), .sclr(sclr),
      .dout(dout_l), .dout_valid(vld_l), .dout_ready(dout_ready),
      .ovf(ovf_l), .ovf_clr(ovf_clr), .bit_cnt(cnt_l));

   typedef struct {
      logic       d, en, s, r, oc;
      logic [3:0] dout;
      logic       vld, ovf;
      logic [1:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic d, logic en, logic s, logic r, logic oc,
                              logic [3:0] dout, logic vld, logic ovf,
                              logic [1:0] cnt);
      vec_t x;
      x.d = d; x.en = en; x.s = s; x.r = r; x.oc = oc;
      x.dout = dout; x.vld = vld; x.ovf = ovf; x.cnt = cnt;
      return x;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive inputs, take one rising edge, return 1 time unit after it.
   task automatic cyc(input logic d, input logic en, input logic s,
                      input logic r, input logic oc);
      din = d; din_en = en; sclr = s; dout_ready = r; ovf_clr = oc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      din = 0; din_en = 0; sclr = 0; dout_ready = 0; ovf_clr = 0;
      clr = 1'b0;
      repeat (2) @(posedge clk);
      #3 clr = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // basic word, hold, transfer
      tbl.push_back(v(1,1,0,0,0, 4'b0000,0,0,1));
      tbl.push_back(v(0,1,0,0,0, 4'b0000,0,0,2));
      tbl.push_back(v(1,1,0,0,0, 4'b0000,0,0,3));
      tbl.push_back(v(1,1,0,0,0, 4'b1011,1,0,0));
      for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,0,0,0, 4'b1011,1,0,0));
      tbl.push_back(v(0,0,0,1,0, 4'b1011,0,0,0));
      // back-to-back streaming 1010 0110 1111, ready held high
      tbl.push_back(v(1,1,0,1,0, 4'b1011,0,0,1));
      tbl.push_back(v(0,1,0,1,0, 4'b1011,0,0,2));
      tbl.push_back(v(1,1,0,1,0, 4'b1011,0,0,3));
      tbl.push_back(v(0,1,0,1,0, 4'b1010,1,0,0));
      tbl.push_back(v(0,1,0,1,0, 4'b1010,0,0,1));
      tbl.push_back(v(1,1,0,1,0, 4'b1010,0,0,2));
      tbl.push_back(v(1,1,0,1,0, 4'b1010,0,0,3));
      tbl.push_back(v(0,1,0,1,0, 4'b0110,1,0,0));
      tbl.push_back(v(1,1,0,1,0, 4'b0110,0,0,1));
      tbl.push_back(v(1,1,0,1,0, 4'b0110,0,0,2));
      tbl.push_back(v(1,1,0,1,0, 4'b0110,0,0,3));
      tbl.push_back(v(1,1,0,1,0, 4'b1111,1,0,0));
      tbl.push_back(v(0,0,0,1,0, 4'b1111,0,0,0));
      // overflow: 0001 held, 1110 dropped
      tbl.push_back(v(0,1,0,0,0, 4'b1111,0,0,1));
      tbl.push_back(v(0,1,0,0,0, 4'b1111,0,0,2));
      tbl.push_back(v(0,1,0,0,0, 4'b1111,0,0,3));
      tbl.push_back(v(1,1,0,0,0, 4'b0001,1,0,0));
      tbl.push_back(v(1,1,0,0,0, 4'b0001,1,0,1));
      tbl.push_back(v(1,1,0,0,0, 4'b0001,1,0,2));
      tbl.push_back(v(1,1,0,0,0, 4'b0001,1,0,3));
      tbl.push_back(v(0,1,0,0,0, 4'b0001,1,1,0));
      tbl.push_back(v(0,0,0,0,1, 4'b0001,1,0,0));
      tbl.push_back(v(0,0,0,1,0, 4'b0001,0,0,0));
      // simultaneous transfer and completion: A=1100 pending, B=0011
      tbl.push_back(v(1,1,0,0,0, 4'b0001,0,0,1));
      tbl.push_back(v(1,1,0,0,0, 4'b0001,0,0,2));
      tbl.push_back(v(0,1,0,0,0, 4'b0001,0,0,3));
      tbl.push_back(v(0,1,0,0,0, 4'b1100,1,0,0));
      tbl.push_back(v(0,1,0,0,0, 4'b1100,1,0,1));
      tbl.push_back(v(0,1,0,0,0, 4'b1100,1,0,2));
      tbl.push_back(v(1,1,0,0,0, 4'b1100,1,0,3));
      tbl.push_back(v(1,1,0,1,0, 4'b0011,1,0,0));
      tbl.push_back(v(0,0,0,1,0, 4'b0011,0,0,0));
      // sclr mid-word, then full word 0101
      tbl.push_back(v(1,1,0,0,0, 4'b0011,0,0,1));
      tbl.push_back(v(1,1,0,0,0, 4'b0011,0,0,2));
      tbl.push_back(v(0,1,1,0,0, 4'b0011,0,0,0));
      tbl.push_back(v(0,1,0,0,0, 4'b0011,0,0,1));
      tbl.push_back(v(1,1,0,0,0, 4'b0011,0,0,2));
      tbl.push_back(v(0,1,0,0,0, 4'b0011,0,0,3));
      tbl.push_back(v(1,1,0,0,0, 4'b0101,1,0,0));
      // sclr on would-be completion edge: no load, no overflow
      tbl.push_back(v(1,1,0,0,0, 4'b0101,1,0,1));
      tbl.push_back(v(1,1,0,0,0, 4'b0101,1,0,2));
      tbl.push_back(v(1,1,0,0,0, 4'b0101,1,0,3));
      tbl.push_back(v(1,1,1,0,0, 4'b0101,1,0,0));
      tbl.push_back(v(0,0,0,1,0, 4'b0101,0,0,0));

      do_reset();
      chk("reset dout", dout_m, 0);
      chk("reset valid", vld_m, 0);
      chk("reset ovf", ovf_m, 0);
      chk("reset cnt", cnt_m, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].d, tbl[i].en, tbl[i].s, tbl[i].r, tbl[i].oc);
         chk($sformatf("row%0d dout", i), dout_m, tbl[i].dout);
         chk($sformatf("row%0d valid", i), vld_m, tbl[i].vld);
         chk($sformatf("row%0d ovf", i), ovf_m, tbl[i].ovf);
         chk($sformatf("row%0d cnt", i), cnt_m, tbl[i].cnt);
      end

      // ovf_clr coinciding with an overflow: set wins
      cyc(1,1,0,0,0); cyc(0,1,0,0,0); cyc(0,1,0,0,0); cyc(1,1,0,0,0);
      chk("setwin first word", dout_m, 4'b1001);
      cyc(0,1,0,0,0); cyc(1,1,0,0,0); cyc(1,1,0,0,0); cyc(0,1,0,0,1);
      chk("setwin ovf", ovf_m, 1);
      chk("setwin dout kept", dout_m, 4'b1001);
      chk("setwin valid", vld_m, 1);

      // asynchronous reset between edges with a word pending and ovf set
      cyc(1,1,0,0,0);
      chk("pre-reset cnt", cnt_m, 1);
      din_en = 0;
      #3 clr = 1'b0;
      #1;
      chk("async valid", vld_m, 0);
      chk("async dout", dout_m, 0);
      chk("async ovf", ovf_m, 0);
      chk("async cnt", cnt_m, 0);
      @(posedge clk);
      #3 clr = 1'b1;
      @(posedge clk);
      #1;

      // LSB-first with gapped din_en: bits 1,1,0,0 -> 0011
      cyc(1,1,0,0,0); chk("lsb cnt1", cnt_l, 1);
      cyc(0,0,0,0,0); chk("lsb gap1", cnt_l, 1);
      cyc(1,1,0,0,0); chk("lsb cnt2", cnt_l, 2);
      cyc(1,0,0,0,0); chk("lsb gap2", cnt_l, 2);
      cyc(0,1,0,0,0); chk("lsb cnt3", cnt_l, 3);
      cyc(1,0,0,0,0); chk("lsb gap3", cnt_l, 3);
      chk("lsb not valid", vld_l, 0);
      cyc(0,1,0,0,0);
      chk("lsb dout", dout_l, 4'b0011);
      chk("lsb valid", vld_l, 1);
      chk("lsb cnt wrap", cnt_l, 0);
      chk("lsb ovf", ovf_l, 0);
      cyc(0,0,0,1,0);
      chk("lsb drained", vld_l, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_serial_to_parallel_collector

// File: doc/serial_to_parallel_collector.md
Name: serial_to_parallel_collector

Overview:
- Downstream stage of the D-flip-flop shift-register chain. Consumes the serial bit stream at the chain's last stage output.
- Assembles WIDTH consecutive qualified bits into a parallel word.
- Presents each word on a valid/ready output port, with a one-word holding register and a sticky overflow flag.
- Lets the 4-bit shift-register datapath hand words to a parallel consumer without losing alignment.

Parameters:
- WIDTH, 4, bits per assembled word (legal 2..16).
- CNT_W, $clog2(WIDTH), width of the internal bit counter.
- MSB_FIRST, 1, 1 = first received bit lands in word MSB; 0 = first received bit lands in LSB.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- clr  input  1  asynchronous, active-low reset (0 = reset)
- din  input  1  serial data bit from upstream shift-register stage output
- din_en  input  1  bit qualifier; din sampled only on edges where din_en=1
- sclr  input  1  synchronous clear of partial word; active-high
- dout  output  WIDTH  assembled word, held stable while dout_valid=1 and dout_ready=0
- dout_valid  output  1  word available
- dout_ready  input  1  consumer accepts word when dout_valid=1 and dout_ready=1 on a rising edge
- ovf  output  1  sticky overflow: a completed word was dropped
- ovf_clr  input  1  synchronous clear of ovf
- bit_cnt  output  CNT_W  bits collected into the current partial word (status)

Behaviour:
- Reset (clr=0, asynchronous), all state forced to 0: shift register, bit counter, dout, dout_valid, ovf, bit_cnt. Reset mid-word discards the partial word. Reset deassertion is synchronised externally.
- Collection: on each edge with din_en=1, din is shifted into the internal shift register and the bit counter increments.
  - MSB_FIRST=1: shift left, din enters bit 0.
  - MSB_FIRST=0: shift right, din enters bit WIDTH-1.
- Word completion: the edge that samples the WIDTH-th bit (counter == WIDTH-1 with din_en=1) is the completion edge.
  - Counter wraps to 0 on the completion edge. The shift register needs no clear.
  - The completed word, including the bit sampled on that edge, is written to the dout register on the same edge.
  - dout_valid=1 after that edge, i.e. one cycle after the last bit is presented.
- Handshake:
  - dout/dout_valid are registered outputs.
  - Transfer occurs on an edge with dout_valid=1 and dout_ready=1. After a transfer with no simultaneous completion, dout_valid=0.
  - dout_ready is ignored when dout_valid=0.
  - dout is held constant while valid and not ready.
- Simultaneous transfer and completion on the same edge: the new word loads, dout_valid stays 1, no overflow.
- Overflow: completion edge with dout_valid=1 and dout_ready=0.
  - The new word is dropped and dout keeps the old word.
  - ovf is set and stays set until ovf_clr=1 or reset.
  - Counter still wraps, so word alignment is preserved.
  - ovf_clr and an overflow event on the same edge: ovf ends at 1 (set wins).
- sclr=1: counter and shift register go to 0 on the next edge. Any din_en on that edge is ignored.
  - sclr does not affect dout, dout_valid or ovf.
  - sclr has priority over completion.
- din_en=0 cycles: all collection state holds. Gaps between bits are unlimited.
- bit_cnt equals the internal counter: 0..WIDTH-1.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package: bit-order constants MSB_FIRST_C=1 and LSB_FIRST_C=0; default word width constant SR_WIDTH=4, used by the shift-register chain and this block.
- One natural sub-module: collector_out_reg, the valid/ready holding register with overflow detect. Inputs: load, word; outputs: dout, dout_valid, ovf.
- Shift register and counter remain in the top.

Test Plan (WIDTH=4, MSB_FIRST=1 unless stated):
- Reset/basic: clr=0 then release; drive din=1,0,1,1 with din_en=1 on 4 consecutive edges, dout_ready=0 -> one cycle after 4th bit, dout=4'b1011, dout_valid=1, bit_cnt=0; hold ready=0 for 5 cycles -> dout stable; ready=1 one edge -> dout_valid=0.
- Gapped bits and LSB order: MSB_FIRST=0; bits 1,1,0,0 with din_en toggling 1/0 each cycle -> dout=4'b0011 after 4th qualified bit, intermediate bit_cnt 1,2,3.
- Back-to-back streaming: dout_ready=1 constant; continuous din_en=1, stream 1010_0110_1111 -> dout_valid pulses one cycle every 4 cycles; words 1010, 0110, 1111; ovf=0.
- Overflow: ready=0; 8 bits 0001 then 1110 -> dout=0001 retained, ovf=1 after 8th bit; ovf_clr=1 -> ovf=0; ready=1 -> transfers 0001.
- Simultaneous transfer/completion: word A pending; ready=1 on the same edge as the next word's 4th bit -> dout=word B, dout_valid stays 1, ovf=0.
- Mid-word clears: 2 bits collected, sclr=1 -> bit_cnt=0, next 4 bits form a full word. Separately, clr=0 asserted asynchronously between edges with dout_valid=1 -> dout_valid, dout, ovf, bit_cnt go to 0 immediately.
